// File: rtl/mc_pkg.sv
// Shared definitions for the motion compensator: geometry constants, the
// controller state type and the search-window address helper.
// Optional feature macro: MC_RESIDUAL_OUT_EN (adds reference port and residual).
package mc_pkg;

  localparam int BLOCK_DIM  = 16;
  localparam int WINDOW_DIM = 32;
  localparam int WIN_OFFSET = 8;

  localparam int PIX_W  = 8;   // pixel width
  localparam int ADDR_W = 10;  // search-window byte address (32x32)
  localparam int IDX_W  = 8;   // raster index inside the 16x16 block
  localparam int RES_W  = 9;   // signed residual width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mc_state_t;

  // Window byte address of block pixel (r, c) displaced by (mvx, mvy).
  // The offset keeps every legal vector inside the window, so the 11-bit
  // signed sum is always 0..990 and the truncation to 10 bits is lossless.
  function automatic logic [ADDR_W-1:0] mc_search_addr(
    input logic        [3:0] r,
    input logic        [3:0] c,
    input logic signed [3:0] mvx,
    input logic signed [3:0] mvy
  );
    logic signed [10:0] row;
    logic signed [10:0] col;
    row = $signed(11'(WIN_OFFSET)) + $signed({7'b0, r}) + $signed({{7{mvy[3]}}, mvy});
    col = $signed(11'(WIN_OFFSET)) + $signed({7'b0, c}) + $signed({{7{mvx[3]}}, mvx});
    return ADDR_W'((row <<< 5) + col);
  endfunction

endpackage

// File: rtl/motion_compensator_if.sv
// Bus bundle of the motion compensator: start/vector request, search-memory
// read port, predicted-pixel stream and completion flag.
// Optional feature macro: MC_RESIDUAL_OUT_EN (reference read port + residual).
interface motion_compensator_if;
  import mc_pkg::*;

  logic                    start_signal;
  logic [3:0]              motion_vector_x;
  logic [3:0]              motion_vector_y;
  logic [ADDR_W-1:0]       address_search;
  logic [PIX_W-1:0]        search_data;
  logic                    pred_valid;
  logic [IDX_W-1:0]        pred_address;
  logic [PIX_W-1:0]        pred_data;
  logic                    process_completed;
`ifdef MC_RESIDUAL_OUT_EN
  logic [IDX_W-1:0]        address_ref;
  logic [PIX_W-1:0]        ref_data;
  logic signed [RES_W-1:0] residual;
`endif

  // Compensator side.
  modport master (
`ifdef MC_RESIDUAL_OUT_EN
    input  ref_data,
    output address_ref, residual,
`endif
    input  start_signal, motion_vector_x, motion_vector_y, search_data,
    output address_search, pred_valid, pred_address, pred_data, process_completed
  );

  // Requester / memory side.
  modport slave (
`ifdef MC_RESIDUAL_OUT_EN
    output ref_data,
    input  address_ref, residual,
`endif
    output start_signal, motion_vector_x, motion_vector_y, search_data,
    input  address_search, pred_valid, pred_address, pred_data, process_completed
  );

endinterface

// File: rtl/mc_addr_gen.sv
// Address generator: pixel counter, latched motion vector and the registered
// search-memory address for the pixel currently being fetched.
module mc_addr_gen
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,     // IDLE -> FETCH: latch vectors, restart count
  input  logic              fetch,    // FETCH: step to the next pixel
  input  logic [3:0]        mvx_in,
  input  logic [3:0]        mvy_in,
  output logic [IDX_W-1:0]  count,    // raster index of the address on the bus
  output logic              last,     // last pixel of the block is on the bus
  output logic [ADDR_W-1:0] address
);

  logic signed [3:0] mvx_q;
  logic signed [3:0] mvy_q;
  logic [IDX_W-1:0]  count_next;

  assign count_next = count + IDX_W'(1);
  assign last       = (count == IDX_W'(BLOCK_DIM * BLOCK_DIM - 1));

  // Counter, vector latch and address register; address is 0 outside a fetch.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, exactly like the flops it describes.
    if (reset) begin
      count   <= '0;
      mvx_q   <= '0;
      mvy_q   <= '0;
      address <= '0;
    end else if (load) begin
      count   <= '0;
      mvx_q   <= mvx_in;
      mvy_q   <= mvy_in;
      address <= mc_search_addr(4'd0, 4'd0, mvx_in, mvy_in);
    end else if (fetch) begin
      count   <= count_next;
      address <= last ? '0
                      : mc_search_addr(count_next[7:4], count_next[3:0], mvx_q, mvy_q);
    end else begin
      address <= '0;
    end
  end

endmodule

// File: rtl/motion_compensator.sv
// Motion compensator: walks the 32x32 search window at the latched motion
// vector and streams the 16x16 predicted block in raster order.
// Optional feature macro: MC_RESIDUAL_OUT_EN (reference read + residual output).
module motion_compensator
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  motion_compensator_if.master bus
);

  mc_state_t        state_q;
  mc_state_t        state_d;
  logic             load;
  logic             fetch;
  logic             last;
  logic [IDX_W-1:0] count;
  logic             pred_valid_q;
  logic [IDX_W-1:0] pred_address_q;

  assign load  = (state_q == IDLE) && bus.start_signal;
  assign fetch = (state_q == FETCH);

  mc_addr_gen u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .fetch   (fetch),
    .mvx_in  (bus.motion_vector_x),
    .mvy_in  (bus.motion_vector_y),
    .count   (count),
    .last    (last),
    .address (bus.address_search)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred when a branch does not mention state_d.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_signal)  state_d = FETCH;
      FETCH:   if (last)              state_d = DRAIN;
      DRAIN:                          state_d = DONE;
      DONE:    if (!bus.start_signal) state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Valid/index pipeline: one cycle behind the address, matching the memory's
  // read latency so the returning byte and its index line up.
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid_q   <= 1'b0;
      pred_address_q <= '0;
    end else begin
      pred_valid_q   <= fetch;
      pred_address_q <= fetch ? count : '0;
    end
  end

  // The memory's own read register supplies the data stage; the byte is
  // forwarded while valid and forced to 0 otherwise.
  assign bus.pred_valid        = pred_valid_q;
  assign bus.pred_address      = pred_address_q;
  assign bus.pred_data         = pred_valid_q ? bus.search_data : '0;
  assign bus.process_completed = (state_q == DONE);

`ifdef MC_RESIDUAL_OUT_EN
  // Reference pixels are read in lockstep with the search pixels, so the
  // residual pairs bytes of the same raster index.
  assign bus.address_ref = count;
  assign bus.residual    = pred_valid_q
                         ? $signed({1'b0, bus.ref_data} - {1'b0, bus.search_data})
                         : '0;
`endif

endmodule

// File: tb/tb_motion_compensator.sv
// Self-checking bench for motion_compensator: random search window, behavioural
// memory and a raster-order reference of the predicted block.
module tb_motion_compensator;
  import mc_pkg::*;

  logic clk;
  logic reset;
  int   passed;
  int   failed;
  int   total;

  logic [7:0] window  [1024];
  logic [7:0] ref_mem [256];

  motion_compensator_if mc_if ();

  motion_compensator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mc_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: data one cycle after the address.
  always @(posedge clk) mc_if.search_data <= window[mc_if.address_search];
`ifdef MC_RESIDUAL_OUT_EN
  always @(posedge clk) mc_if.ref_data <= ref_mem[mc_if.address_ref];
`endif

  // Window byte that pixel k of the block maps to under vector (mvx, mvy).
  function automatic int model_addr(input int k, input int mvx, input int mvy);
    return (WIN_OFFSET + k / BLOCK_DIM + mvy) * WINDOW_DIM + (WIN_OFFSET + k % BLOCK_DIM + mvx);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"},  32'(mc_if.address_search), 32'd0);
    check({tag, "_valid"}, 32'(mc_if.pred_valid), 32'd0);
    check({tag, "_paddr"}, 32'(mc_if.pred_address), 32'd0);
    check({tag, "_pdata"}, 32'(mc_if.pred_data), 32'd0);
    check({tag, "_done"},  32'(mc_if.process_completed), 32'd0);
    check({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
`ifdef MC_RESIDUAL_OUT_EN
    check({tag, "_aref"},  32'(mc_if.address_ref), 32'd0);
    check({tag, "_res"},   32'(mc_if.residual), 32'd0);
`endif
  endtask

  // Start must already be high; waits the sampling edge N and checks cycles
  // N+1..N+258. The vector inputs are scrambled meanwhile and must be ignored.
  task automatic check_block(input int mvx, input int mvy);
    int k;
    int a;
    logic [8:0] exp_res;
    @(posedge clk);
    for (int cyc = 1; cyc <= 258; cyc++) begin
      #1;
      if (cyc <= 256) begin
        check("addr", 32'(mc_if.address_search), 32'(model_addr(cyc - 1, mvx, mvy)));
`ifdef MC_RESIDUAL_OUT_EN
        check("addr_ref", 32'(mc_if.address_ref), 32'(cyc - 1));
`endif
      end
      check("pred_valid", 32'(mc_if.pred_valid), 32'(cyc >= 2 && cyc <= 257));
      if (cyc >= 2 && cyc <= 257) begin
        k = cyc - 2;
        a = model_addr(k, mvx, mvy);
        check("pred_address", 32'(mc_if.pred_address), 32'(k));
        check("pred_data", 32'(mc_if.pred_data), 32'(window[a]));
`ifdef MC_RESIDUAL_OUT_EN
        exp_res = 9'(int'(ref_mem[k]) - int'(window[a]));
        check("residual", 32'(mc_if.residual), 32'(exp_res));
`endif
      end
      check("done", 32'(mc_if.process_completed), 32'(cyc == 258));
      if (cyc < 258) begin
        @(negedge clk);
        mc_if.motion_vector_x = 4'($urandom);
        mc_if.motion_vector_y = 4'($urandom);
        @(posedge clk);
      end
    end
  endtask

  task automatic start_block(input int mvx, input int mvy);
    @(negedge clk);
    mc_if.motion_vector_x = 4'(mvx);
    mc_if.motion_vector_y = 4'(mvy);
    mc_if.start_signal    = 1'b1;
    check_block(mvx, mvy);
  endtask

  task automatic end_block();
    @(negedge clk);
    mc_if.start_signal = 1'b0;
    @(posedge clk);
    #1;
    check("done_fall", 32'(mc_if.process_completed), 32'd0);
    check("idle_after_done", 32'(dut.state_q), 32'(IDLE));
  endtask

  initial begin
    int mvx;
    int mvy;
    passed = 0;
    failed = 0;
    total  = 0;
    for (int i = 0; i < 1024; i++) window[i] = 8'($urandom);
    for (int i = 0; i < 256; i++)  ref_mem[i] = 8'($urandom);
    reset = 1'b1;
    mc_if.start_signal    = 1'b0;
    mc_if.motion_vector_x = 4'd0;
    mc_if.motion_vector_y = 4'd0;
`ifndef MC_RESIDUAL_OUT_EN
    mc_if.search_data = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Zero vector, then both window extremes.
    start_block(0, 0);
    end_block();
    start_block(-8, -8);
    end_block();
    start_block(7, 7);
    end_block();

    // Reference block cut out of the window at (+3,-5): prediction must match
    // it byte for byte, so every residual is zero.
    for (int k = 0; k < 256; k++) ref_mem[k] = window[model_addr(k, 3, -5)];
    start_block(3, -5);
    end_block();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);

    // Reset in the middle of a block, at pred_address 100.
    @(negedge clk);
    mc_if.motion_vector_x = 4'd2;
    mc_if.motion_vector_y = 4'hD;
    mc_if.start_signal    = 1'b1;
    @(posedge clk);
    repeat (101) @(posedge clk);
    #1;
    check("mid_valid", 32'(mc_if.pred_valid), 32'd1);
    check("mid_paddr", 32'(mc_if.pred_address), 32'd100);
    @(negedge clk);
    reset = 1'b1;
    mc_if.start_signal = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    mvx = int'($urandom_range(0, 15)) - 8;
    mvy = int'($urandom_range(0, 15)) - 8;
    start_block(mvx, mvy);
    end_block();

    // Reset and start together: reset wins, block starts on the next edge.
    @(negedge clk);
    mvx = int'($urandom_range(0, 15)) - 8;
    mvy = int'($urandom_range(0, 15)) - 8;
    mc_if.motion_vector_x = 4'(mvx);
    mc_if.motion_vector_y = 4'(mvy);
    mc_if.start_signal    = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("reset_start");
    @(negedge clk);
    reset = 1'b0;
    mc_if.motion_vector_x = 4'(mvx);
    mc_if.motion_vector_y = 4'(mvy);
    check_block(mvx, mvy);

    // Start held through DONE: no restart, completion stays high.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("held_done", 32'(mc_if.process_completed), 32'd1);
      check("held_valid", 32'(mc_if.pred_valid), 32'd0);
    end
    // One low cycle, then a new block at freshly latched vectors.
    end_block();
    mvx = int'($urandom_range(0, 15)) - 8;
    mvy = int'($urandom_range(0, 15)) - 8;
    start_block(mvx, mvy);
    end_block();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
